// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: pixel-rate counters, sync/blank decode and
// downscaled ROM coordinates, plus sync/blank copies aligned to the ROM read latency.
module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_DIV   = 4,
  parameter int X_SCALE   = 5,
  parameter int Y_SHIFT   = 3,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic       video_on,
  output logic [6:0] x,
  output logic [5:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       video_on_d,
  output logic       hsync_d,
  output logic       vsync_d
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  // vcount must be wide enough to slice the 6-bit ROM row out of it
  localparam int VW = ($clog2(V_TOTAL) > Y_SHIFT + 6) ? $clog2(V_TOTAL) : Y_SHIFT + 6;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int XW = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
  localparam logic [XW-1:0] XSUB_LAST = XW'(X_SCALE - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [XW-1:0] xsub_q, xsub_d;
  logic [6:0]    xcol_q, xcol_d;
  logic          tick, h_vis, v_vis, h_last, v_last;

  logic          pix_tick_q, video_on_q, hsync_q, vsync_q, frame_start_q;
  logic [6:0]    x_q;
  logic [5:0]    y_q;
  logic [2:0]    dly_q [LATENCY];

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    h_vis     = (hcount_q < H_VIS);
    v_vis     = (vcount_q < V_VIS);
    h_last    = (hcount_q == H_LAST);
    v_last    = (vcount_q == V_LAST);
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    xsub_d    = xsub_q;
    xcol_d    = xcol_q;
    // counters advance on the registered tick, so outputs below see the pre-advance position
    if (pix_tick_q) begin
      if (h_last) begin
        hcount_d = '0;
        xsub_d   = '0;
        xcol_d   = '0;
        vcount_d = v_last ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
        if (h_vis) begin
          if (xsub_q == XSUB_LAST) begin
            xsub_d = '0;
            if (xcol_q != 7'd127) xcol_d = xcol_q + 7'd1;
          end else begin
            xsub_d = xsub_q + XW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      xsub_q        <= '0;
      xcol_q        <= '0;
      pix_tick_q    <= 1'b0;
      video_on_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) dly_q[i] <= 3'b011;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      xsub_q        <= xsub_d;
      xcol_q        <= xcol_d;
      pix_tick_q    <= tick;
      frame_start_q <= 1'b0;
      if (pix_tick_q) begin
        video_on_q    <= h_vis && v_vis;
        x_q           <= (h_vis && v_vis) ? xcol_q : 7'd0;
        y_q           <= v_vis ? vcount_q[Y_SHIFT+5:Y_SHIFT] : 6'd0;
        hsync_q       <= !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
        vsync_q       <= !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
        frame_start_q <= h_last && v_last;
      end
      dly_q[0] <= {video_on_q, hsync_q, vsync_q};
      for (int i = 1; i < LATENCY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign pix_tick    = pix_tick_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign video_on_d  = dly_q[LATENCY-1][2];
  assign hsync_d     = dly_q[LATENCY-1][1];
  assign vsync_d     = dly_q[LATENCY-1][0];
endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: three instances (default/PIX_DIV=4, default/PIX_DIV=1,
// small geometry/PIX_DIV=2) checked every clk against an arithmetic raster model.
module tb_vga_scan_gen;
  typedef struct packed {
    logic       pt, von;
    logic [6:0] x;
    logic [5:0] y;
    logic       hs, vs, fs, vond, hsd, vsd;
  } obs_t;

  typedef struct packed { int D, HV, HF, HS, HB, VV, VF, VS, VB; } geo_t;

  localparam obs_t RST_O = '{pt:1'b0, von:1'b0, x:7'd0, y:6'd0, hs:1'b1, vs:1'b1,
                             fs:1'b0, vond:1'b0, hsd:1'b1, vsd:1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [3];
  logic       pt [3], von [3], hs [3], vs [3], fs [3], vond [3], hsd [3], vsd [3];
  logic [6:0] xx [3];
  logic [5:0] yy [3];

  vga_scan_gen #(.PIX_DIV(4)) u_a (
    .clk(clk), .rst(rst_v[0]), .pix_tick(pt[0]), .video_on(von[0]), .x(xx[0]), .y(yy[0]),
    .hsync(hs[0]), .vsync(vs[0]), .frame_start(fs[0]), .video_on_d(vond[0]),
    .hsync_d(hsd[0]), .vsync_d(vsd[0]));

  vga_scan_gen #(.PIX_DIV(1)) u_b (
    .clk(clk), .rst(rst_v[1]), .pix_tick(pt[1]), .video_on(von[1]), .x(xx[1]), .y(yy[1]),
    .hsync(hs[1]), .vsync(vs[1]), .frame_start(fs[1]), .video_on_d(vond[1]),
    .hsync_d(hsd[1]), .vsync_d(vsd[1]));

  vga_scan_gen #(.H_VISIBLE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
                 .V_VISIBLE(24), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIX_DIV(2)) u_c (
    .clk(clk), .rst(rst_v[2]), .pix_tick(pt[2]), .video_on(von[2]), .x(xx[2]), .y(yy[2]),
    .hsync(hs[2]), .vsync(vs[2]), .frame_start(fs[2]), .video_on_d(vond[2]),
    .hsync_d(hsd[2]), .vsync_d(vsd[2]));

  function automatic geo_t geo(int k);
    geo_t g;
    if (k == 2) g = '{D:2, HV:40, HF:4, HS:6, HB:5, VV:24, VF:2, VS:2, VB:3};
    else        g = '{D:(k == 0) ? 4 : 1, HV:640, HF:16, HS:96, HB:48,
                      VV:480, VF:10, VS:2, VB:33};
    return g;
  endfunction

  // Expected undelayed outputs n clks after reset release: the pixel shown is simply
  // the n-th pixel period's raster position, derived by division/modulo.
  function automatic obs_t undl(geo_t g, int n);
    obs_t o;
    int p, hc, vc, ht, vt;
    bit upd;
    o  = RST_O;
    ht = g.HV + g.HF + g.HS + g.HB;
    vt = g.VV + g.VF + g.VS + g.VB;
    o.pt = (n >= g.D) && (n % g.D == 0);
    if (n >= g.D + 1) begin
      p   = (n - g.D - 1) / g.D;
      upd = ((n - g.D - 1) % g.D) == 0;
      hc  = p % ht;
      vc  = (p / ht) % vt;
      o.von = (hc < g.HV) && (vc < g.VV);
      o.x   = o.von ? 7'(hc / 5) : 7'd0;
      o.y   = (vc < g.VV) ? 6'(vc / 8) : 6'd0;
      o.hs  = !((hc >= g.HV + g.HF) && (hc < g.HV + g.HF + g.HS));
      o.vs  = !((vc >= g.VV + g.VF) && (vc < g.VV + g.VF + g.VS));
      o.fs  = upd && (hc == ht - 1) && (vc == vt - 1);
    end
    return o;
  endfunction

  function automatic obs_t model(int k, int n);
    obs_t o, d;
    o = undl(geo(k), n);
    d = undl(geo(k), n - 2);
    o.vond = d.von;
    o.hsd  = d.hs;
    o.vsd  = d.vs;
    return o;
  endfunction

  function automatic obs_t sample(int k);
    return '{pt:pt[k], von:von[k], x:xx[k], y:yy[k], hs:hs[k], vs:vs[k], fs:fs[k],
             vond:vond[k], hsd:hsd[k], vsd:vsd[k]};
  endfunction

  int   total = 0, passed = 0;
  int   ncnt [3] = '{0, 0, 0};
  obs_t q0 [$], q1 [$], q2 [$];
  bit   done = 1'b0;

  task automatic check(string name, int k, obs_t got, obs_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s inst%0d n=%0d got=%h exp=%h", name, k, ncnt[k], got, exp);
  endtask

  // Reference side: track clks since release and push the expected response.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) ncnt[k] = 0;
      else          ncnt[k] = ncnt[k] + 1;
      case (k)
        0: q0.push_back(model(0, ncnt[0]));
        1: q1.push_back(model(1, ncnt[1]));
        default: q2.push_back(model(2, ncnt[2]));
      endcase
    end
  end

  // Monitor: the outputs are presented every clk; compare on the falling edge.
  initial forever begin
    obs_t e;
    @(negedge clk);
    if (!done) begin
      if (q0.size() > 0) begin e = q0.pop_front(); check("scan", 0, sample(0), e); end
      if (q1.size() > 0) begin e = q1.pop_front(); check("scan", 1, sample(1), e); end
      if (q2.size() > 0) begin e = q2.pop_front(); check("scan", 2, sample(2), e); end
    end
  end

  task automatic drive(int k, int run, int lo, int hi);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    #1 rst_v[k] = 1'b0;
    repeat (run) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(lo, hi)) @(negedge clk);
      #1 rst_v[k] = 1'b1;
      #1 check("async_rst", k, sample(k), RST_O);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1 rst_v[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check("reset", k, sample(k), RST_O);
    drive(0, 2 * 3200 + 400, 1150, 1300);
    drive(1, 2000, 250, 350);
    drive(2, 2 * 3410 + 200, 100, 2000);
    repeat (50) @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
